blinds_motor_driver: RTL and testbench
======================================

Name: blinds_motor_driver

Overview:
Actuator side of the blinds command interface. Consumes the open/close decision (1 = open, 0 = close) through a valid/ready handshake and drives a two-wire up/down motor until the matching limit switch trips. Tracks blind position, enforces a motor-off dead time on direction reversal, and latches a fault on travel timeout or on contradictory limit switches.

Parameters:
POS_MAX, 200, position count at fully open; position 0 is fully closed.
TIMEOUT_TICKS, 250, step ticks allowed per travel before fault; must be greater than POS_MAX.
DEAD_TICKS, 4, clock cycles with both motor outputs low before a direction reversal.

Ports:
clk_i  input  1  system clock, rising edge.
rst_ni  input  1  synchronous active-low reset.
blinds_cmd_valid_i  input  1  command present.
blinds_cmd_ready_o  output  1  driver accepts a command this cycle.
blinds_status_i  input  1  target position: 1 = open, 0 = closed.
step_tick_i  input  1  one-cycle travel-step strobe from the shared time base.
open_limit_i  input  1  open limit switch, active high, already synchronised.
closed_limit_i  input  1  closed limit switch, active high, already synchronised.
fault_clear_i  input  1  clears a latched fault.
motor_up_o  output  1  drive toward open.
motor_down_o  output  1  drive toward closed.
position_o  output  8  current position estimate, 0..POS_MAX.
position_valid_o  output  1  position referenced by at least one limit hit since reset.
busy_o  output  1  state is not IDLE.
done_o  output  1  one-cycle pulse when a travel ends at its limit.
fault_o  output  1  latched fault.

Behaviour:
- Reset: rst_ni is sampled on the rising edge of clk_i. Reset puts the FSM in IDLE. All outputs are 0 during and after reset, except blinds_cmd_ready_o, which is 1 from the first cycle after reset.
- All outputs are registered. motor_up_o and motor_down_o are never high together.
- A command is accepted on a cycle where blinds_cmd_valid_i and blinds_cmd_ready_o are both 1.
- blinds_cmd_ready_o is 1 in IDLE, MOVE_UP and MOVE_DOWN. It is 0 in DEAD and FAULT.
- FSM states are IDLE, MOVE_UP, MOVE_DOWN, DEAD and FAULT.
- IDLE transitions:
  - Accepted open with open_limit_i low: go to MOVE_UP.
  - Accepted close with closed_limit_i low: go to MOVE_DOWN.
  - Accepted command whose limit is already active: stay in IDLE, pulse done_o next cycle, motor outputs stay low.
- Latency: a command accepted in cycle N gives a motor output high in cycle N+1.
- MOVE_UP:
  - motor_up_o = 1.
  - Each step_tick_i increments position_o, saturating at POS_MAX.
  - open_limit_i high in cycle N: go to IDLE. Motor is low, done_o = 1, position_o = POS_MAX and position_valid_o = 1, all in cycle N+1.
  - An accepted close command goes to DEAD with a pending direction of down.
  - An accepted open command is absorbed with no effect.
- MOVE_DOWN: mirror of MOVE_UP.
  - motor_down_o = 1.
  - Each step_tick_i decrements position_o, saturating at 0.
  - closed_limit_i forces position_o = 0.
  - An accepted open command goes to DEAD with a pending direction of up.
- DEAD:
  - Both motor outputs are low for exactly DEAD_TICKS cycles.
  - Then go to the pending MOVE state, or to IDLE with a done_o pulse if that direction's limit is already active.
- Travel timeout:
  - Each MOVE state counts step_tick_i from 0, starting at MOVE entry.
  - The count restarts on every MOVE entry.
  - When the count reaches TIMEOUT_TICKS without a limit hit, go to FAULT.
- Sensor fault: open_limit_i and closed_limit_i both high in any non-FAULT state goes to FAULT next cycle. This rule has priority over limit, command and timeout handling.
- FAULT:
  - Motors off, fault_o = 1, position_valid_o = 0.
  - Commands are not accepted.
  - fault_clear_i goes to IDLE with fault_o = 0 next cycle, but only if the two limits are not both high. Otherwise the driver stays in FAULT.
- Simultaneous events:
  - A limit hit and a reversal command in the same cycle: the limit wins. The driver goes to IDLE, the command handshake still completes, and the command is discarded. The producer re-issues it.
  - A step_tick_i arriving in the same cycle as the limit: ignored.
- Reset mid-travel: outputs drop on the next clock edge and position_valid_o returns to 0.

Decomposition:
- Shared header design_constant.vh holds:
  - FSM state encodings.
  - BLINDS_OPEN = 1'b1 and BLINDS_CLOSE = 1'b0.
  - Default POS_MAX, TIMEOUT_TICKS and DEAD_TICKS values.
- One sub-module, blinds_travel_timer: a loadable down-counter with start, tick-enable and expired outputs. It is reused for both the dead-time count (clock-enabled) and the travel timeout (step_tick_i-enabled).

Test Plan:
1. Reset, then open command with 10 step ticks and open_limit_i at tick 10 -> motor_up_o high 1 cycle after accept; on the limit, motor_up_o = 0, done_o pulses once, position_o = 200, position_valid_o = 1.
2. From open, close command with 5 ticks, then open command -> motor_down_o low for exactly 4 cycles, ready = 0 during DEAD, then motor_up_o = 1; motors never high together.
3. Open command with open_limit_i already high -> no motor activity, done_o pulses 1 cycle after accept.
4. Open command with no limit and 250 step ticks -> fault_o = 1, motor_up_o = 0, ready = 0; fault_clear_i -> IDLE, ready = 1.
5. Both limits high while in MOVE_DOWN -> FAULT next cycle; fault_clear_i with both still high -> remains in FAULT.
6. rst_ni low for 1 cycle mid-MOVE_UP at position 50 -> next cycle all outputs 0 except ready = 1; position_o = 0, position_valid_o = 0.

Source files
------------

// File: rtl/blinds_motor_driver_pkg.sv
// Shared constants and FSM state type for the blinds motor driver.
package blinds_motor_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DEAD,
    ST_FAULT
  } state_e;

  localparam logic BLINDS_OPEN  = 1'b1;
  localparam logic BLINDS_CLOSE = 1'b0;

  localparam int unsigned POS_MAX_DEF       = 200;
  localparam int unsigned TIMEOUT_TICKS_DEF = 250;
  localparam int unsigned DEAD_TICKS_DEF    = 4;

endpackage

// File: rtl/blinds_motor_driver_if.sv
// Open/close command handshake between the blinds controller and the driver.
interface blinds_motor_driver_if;
  logic blinds_cmd_valid;
  logic blinds_cmd_ready;
  logic blinds_status;

  modport master (output blinds_cmd_valid, output blinds_status, input blinds_cmd_ready);
  modport slave  (input blinds_cmd_valid, input blinds_status, output blinds_cmd_ready);
endinterface

// File: rtl/blinds_travel_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module blinds_travel_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Load on start (wins over enable), otherwise count down to zero and hold.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= load_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/blinds_motor_driver.sv
// Two-wire blinds motor driver: command handshake, position tracking,
// reversal dead time, travel timeout and limit-switch fault latching.
module blinds_motor_driver
  import blinds_motor_driver_pkg::*;
#(
  parameter int unsigned POS_MAX       = POS_MAX_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned DEAD_TICKS    = DEAD_TICKS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  blinds_motor_driver_if.slave  blinds_cmd,
  input  logic                  step_tick_i,
  input  logic                  open_limit_i,
  input  logic                  closed_limit_i,
  input  logic                  fault_clear_i,
  output logic                  motor_up_o,
  output logic                  motor_down_o,
  output logic [7:0]            position_o,
  output logic                  position_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fault_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [7:0]  POS_MAX_C = 8'(POS_MAX);

  state_e     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic       pos_valid_q, pos_valid_d;
  logic       pend_up_q, pend_up_d;
  logic       done_d;
  logic       motor_up_q, motor_down_q, busy_q, done_q, fault_q, ready_q;
  logic       travel_start, dead_start;
  logic       travel_expired, dead_expired;
  logic       accept, both_limits, in_move;

  assign accept      = blinds_cmd.blinds_cmd_valid && ready_q;
  assign both_limits = open_limit_i && closed_limit_i;
  assign in_move     = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);

  blinds_travel_timer #(.WIDTH(TW)) u_travel_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (travel_start),
    .load_i    (TW'(TIMEOUT_TICKS)),
    .en_i      (step_tick_i && in_move),
    .expired_o (travel_expired)
  );

  // Loaded with DEAD_TICKS-1 so that expiry is seen in the last dead cycle.
  blinds_travel_timer #(.WIDTH(DW)) u_dead_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (dead_start),
    .load_i    (DW'(DEAD_TICKS - 1)),
    .en_i      (state_q == ST_DEAD),
    .expired_o (dead_expired)
  );

  // Next state, position and done; sensor fault first, then limit, timeout, command.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    pend_up_d    = pend_up_q;
    done_d       = 1'b0;
    travel_start = 1'b0;
    dead_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (both_limits) begin
          state_d = ST_FAULT;
        end else if (accept) begin
          if (blinds_cmd.blinds_status == BLINDS_OPEN) begin
            if (open_limit_i) begin
              done_d = 1'b1;
            end else begin
              state_d      = ST_MOVE_UP;
              travel_start = 1'b1;
            end
          end else begin
            if (closed_limit_i) begin
              done_d = 1'b1;
            end else begin
              state_d      = ST_MOVE_DOWN;
              travel_start = 1'b1;
            end
          end
        end
      end
      ST_MOVE_UP: begin
        if (both_limits) begin
          state_d = ST_FAULT;
        end else if (open_limit_i) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          pos_d       = POS_MAX_C;
          pos_valid_d = 1'b1;
        end else begin
          if (step_tick_i && (pos_q < POS_MAX_C)) begin
            pos_d = pos_q + 8'd1;
          end
          if (travel_expired) begin
            state_d = ST_FAULT;
          end else if (accept && (blinds_cmd.blinds_status == BLINDS_CLOSE)) begin
            state_d    = ST_DEAD;
            pend_up_d  = 1'b0;
            dead_start = 1'b1;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (both_limits) begin
          state_d = ST_FAULT;
        end else if (closed_limit_i) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          pos_d       = '0;
          pos_valid_d = 1'b1;
        end else begin
          if (step_tick_i && (pos_q != '0)) begin
            pos_d = pos_q - 8'd1;
          end
          if (travel_expired) begin
            state_d = ST_FAULT;
          end else if (accept && (blinds_cmd.blinds_status == BLINDS_OPEN)) begin
            state_d    = ST_DEAD;
            pend_up_d  = 1'b1;
            dead_start = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (both_limits) begin
          state_d = ST_FAULT;
        end else if (dead_expired) begin
          if (pend_up_q ? open_limit_i : closed_limit_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d      = pend_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
            travel_start = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear_i && !both_limits) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FAULT) begin
      pos_valid_d = 1'b0;
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      pend_up_q    <= 1'b0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      pend_up_q    <= pend_up_d;
      motor_up_q   <= (state_d == ST_MOVE_UP);
      motor_down_q <= (state_d == ST_MOVE_DOWN);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= done_d;
      fault_q      <= (state_d == ST_FAULT);
      ready_q      <= (state_d == ST_IDLE) || (state_d == ST_MOVE_UP) ||
                      (state_d == ST_MOVE_DOWN);
    end
  end

  assign blinds_cmd.blinds_cmd_ready = ready_q;
  assign motor_up_o       = motor_up_q;
  assign motor_down_o     = motor_down_q;
  assign position_o       = pos_q;
  assign position_valid_o = pos_valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign fault_o          = fault_q;

endmodule

// File: tb/tb_blinds_motor_driver.sv
// Directed bench for blinds_motor_driver with hand-computed expectations.
module tb_blinds_motor_driver;

  logic       clk;
  logic       rst_n;
  logic       step_tick, open_limit, closed_limit, fault_clear;
  logic       motor_up, motor_down, pos_valid, busy, done, fault;
  logic [7:0] position;
  int         n_checks;
  int         n_errors;
  int         both_seen;

  blinds_motor_driver_if cmd_if ();

  blinds_motor_driver #(
    .POS_MAX       (200),
    .TIMEOUT_TICKS (250),
    .DEAD_TICKS    (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .blinds_cmd       (cmd_if),
    .step_tick_i      (step_tick),
    .open_limit_i     (open_limit),
    .closed_limit_i   (closed_limit),
    .fault_clear_i    (fault_clear),
    .motor_up_o       (motor_up),
    .motor_down_o     (motor_down),
    .position_o       (position),
    .position_valid_o (pos_valid),
    .busy_o           (busy),
    .done_o           (done),
    .fault_o          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts any cycle where both motor wires are driven together.
  always @(negedge clk) begin
    if (motor_up && motor_down) both_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; both_seen = 0;
    rst_n = 1'b0; step_tick = 1'b0; open_limit = 1'b0; closed_limit = 1'b0;
    fault_clear = 1'b0; cmd_if.blinds_cmd_valid = 1'b0; cmd_if.blinds_status = 1'b0;
    step();
    step();
    check_val("rst_motor_up",   32'(motor_up), 32'd0);
    check_val("rst_motor_down", 32'(motor_down), 32'd0);
    check_val("rst_position",   32'(position), 32'd0);
    check_val("rst_pos_valid",  32'(pos_valid), 32'd0);
    check_val("rst_busy",       32'(busy), 32'd0);
    check_val("rst_done",       32'(done), 32'd0);
    check_val("rst_fault",      32'(fault), 32'd0);
    check_val("rst_ready",      32'(cmd_if.blinds_cmd_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // 1: open travel, 10 ticks then open limit
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t1_motor_up", 32'(motor_up), 32'd1);
    check_val("t1_busy",     32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step_tick = 1'b1; step();
      step_tick = 1'b0; step();
    end
    check_val("t1_pos10", 32'(position), 32'd10);
    open_limit = 1'b1;
    step();
    check_val("t1_lim_motor_up", 32'(motor_up), 32'd0);
    check_val("t1_lim_done",     32'(done), 32'd1);
    check_val("t1_lim_pos",      32'(position), 32'd200);
    check_val("t1_lim_valid",    32'(pos_valid), 32'd1);
    check_val("t1_lim_busy",     32'(busy), 32'd0);
    step();
    check_val("t1_done_once", 32'(done), 32'd0);

    // 2: close, 5 ticks, reverse to open through dead time
    open_limit = 1'b0;
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b0;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t2_motor_down", 32'(motor_down), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step_tick = 1'b1; step();
      step_tick = 1'b0; step();
    end
    check_val("t2_pos195", 32'(position), 32'd195);
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("t2_dead_up",    32'(motor_up), 32'd0);
      check_val("t2_dead_down",  32'(motor_down), 32'd0);
      check_val("t2_dead_ready", 32'(cmd_if.blinds_cmd_ready), 32'd0);
      step();
    end
    check_val("t2_after_dead_up", 32'(motor_up), 32'd1);
    check_val("t2_after_ready",   32'(cmd_if.blinds_cmd_ready), 32'd1);
    check_val("t2_pos_kept",      32'(position), 32'd195);
    open_limit = 1'b1;
    step();
    check_val("t2_done", 32'(done), 32'd1);
    check_val("t2_pos",  32'(position), 32'd200);

    // 3: open while already at the open limit
    step();
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t3_motor_up", 32'(motor_up), 32'd0);
    check_val("t3_done",     32'(done), 32'd1);
    check_val("t3_busy",     32'(busy), 32'd0);
    step();
    check_val("t3_done_end", 32'(done), 32'd0);

    // 4: travel timeout after 250 ticks, then clear
    open_limit = 1'b0;
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t4_motor_up", 32'(motor_up), 32'd1);
    step_tick = 1'b1;
    for (int i = 0; i < 250; i++) step();
    step_tick = 1'b0;
    check_val("t4_not_yet_fault", 32'(fault), 32'd0);
    check_val("t4_pos_sat",       32'(position), 32'd200);
    step();
    check_val("t4_fault",     32'(fault), 32'd1);
    check_val("t4_motor_off", 32'(motor_up), 32'd0);
    check_val("t4_ready",     32'(cmd_if.blinds_cmd_ready), 32'd0);
    check_val("t4_pv",        32'(pos_valid), 32'd0);
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b0;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t4_cmd_ignored", 32'(motor_down), 32'd0);
    check_val("t4_fault_held",  32'(fault), 32'd1);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    check_val("t4_cleared",     32'(fault), 32'd0);
    check_val("t4_clear_ready", 32'(cmd_if.blinds_cmd_ready), 32'd1);

    // 5: contradictory limits during MOVE_DOWN
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b0;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    check_val("t5_motor_down", 32'(motor_down), 32'd1);
    open_limit = 1'b1; closed_limit = 1'b1;
    step();
    check_val("t5_fault",     32'(fault), 32'd1);
    check_val("t5_motor_off", 32'(motor_down), 32'd0);
    fault_clear = 1'b1;
    step();
    check_val("t5_stuck_fault", 32'(fault), 32'd1);
    check_val("t5_stuck_ready", 32'(cmd_if.blinds_cmd_ready), 32'd0);
    open_limit = 1'b0; closed_limit = 1'b0;
    step();
    fault_clear = 1'b0;
    check_val("t5_cleared", 32'(fault), 32'd0);

    // 6: home to closed, open to 50, reset mid-travel
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b0;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    closed_limit = 1'b1;
    step();
    check_val("t6_home_pos", 32'(position), 32'd0);
    check_val("t6_home_pv",  32'(pos_valid), 32'd1);
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0;
    closed_limit = 1'b0;
    step_tick = 1'b1;
    for (int i = 0; i < 50; i++) step();
    step_tick = 1'b0;
    check_val("t6_pos50",  32'(position), 32'd50);
    check_val("t6_moving", 32'(motor_up), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("t6_rst_up",    32'(motor_up), 32'd0);
    check_val("t6_rst_pos",   32'(position), 32'd0);
    check_val("t6_rst_pv",    32'(pos_valid), 32'd0);
    check_val("t6_rst_busy",  32'(busy), 32'd0);
    check_val("t6_rst_ready", 32'(cmd_if.blinds_cmd_ready), 32'd1);
    step();
    check_val("t6_stay_idle", 32'(motor_up), 32'd0);

    // 7: limit hit and reversal command in the same cycle
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b1; cmd_if.blinds_status = 1'b0;
    open_limit = 1'b1; step_tick = 1'b1;
    step();
    cmd_if.blinds_cmd_valid = 1'b0; step_tick = 1'b0;
    check_val("t7_done",   32'(done), 32'd1);
    check_val("t7_up",     32'(motor_up), 32'd0);
    check_val("t7_down",   32'(motor_down), 32'd0);
    check_val("t7_ready",  32'(cmd_if.blinds_cmd_ready), 32'd1);
    check_val("t7_pos",    32'(position), 32'd200);
    step();
    check_val("t7_discarded", 32'(motor_down), 32'd0);

    check_val("never_both_motors", 32'(both_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
